// File: rtl/ha_response_checker_if.sv
// rtl/ha_response_checker_if.sv - control/status and half-adder stimulus bus for ha_response_checker (optional HA_CHK_FIRST_FAIL_EN)
interface ha_response_checker_if;
    logic       start;
    logic       dut_sum;
    logic       dut_carry;
    logic       stim_a;
    logic       stim_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] vec_idx;
`ifdef HA_CHK_FIRST_FAIL_EN
    logic       first_fail_valid;
    logic [1:0] first_fail_idx;
    logic [1:0] first_fail_obs;
`endif

    // checker side: drives stimulus and status, samples start and the half-adder response
    modport master (
        input  start,
        input  dut_sum,
        input  dut_carry,
        output stim_a,
        output stim_b,
        output busy,
        output done,
        output pass,
        output err_count,
        output vec_idx
`ifdef HA_CHK_FIRST_FAIL_EN
        ,
        output first_fail_valid,
        output first_fail_idx,
        output first_fail_obs
`endif
    );

    // environment side: requests sweeps, hosts the half-adder under test
    modport slave (
        output start,
        output dut_sum,
        output dut_carry,
        input  stim_a,
        input  stim_b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  vec_idx
`ifdef HA_CHK_FIRST_FAIL_EN
        ,
        input  first_fail_valid,
        input  first_fail_idx,
        input  first_fail_obs
`endif
    );
endinterface

// File: rtl/ha_response_checker.sv
// rtl/ha_response_checker.sv - four-vector half-adder sweep checker (optional first-fail capture: HA_CHK_FIRST_FAIL_EN)
module ha_response_checker #(
    parameter int unsigned PERIOD = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ha_response_checker_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] RELOAD = 8'(PERIOD - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] err_q, err_d;
    logic       stim_a_q, stim_a_d;
    logic       stim_b_q, stim_b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [1:0] idx_inc;
    logic       exp_sum;
    logic       exp_carry;
    logic       mismatch;

    // vector k drives a = k[1], b = k[0], so the expected response follows from the index alone
    assign idx_inc   = idx_q + 2'd1;
    assign exp_sum   = idx_q[1] ^ idx_q[0];
    assign exp_carry = idx_q[1] & idx_q[0];
    assign mismatch  = (bus.dut_sum != exp_sum) || (bus.dut_carry != exp_carry);

`ifdef HA_CHK_FIRST_FAIL_EN
    logic       ff_valid_q, ff_valid_d;
    logic [1:0] ff_idx_q, ff_idx_d;
    logic [1:0] ff_obs_q, ff_obs_d;
`endif

    // next-state and datapath updates; everything holds unless a transition says otherwise
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        err_d    = err_q;
        stim_a_d = stim_a_q;
        stim_b_d = stim_b_q;
        busy_d   = busy_q;
        done_d   = done_q;
`ifdef HA_CHK_FIRST_FAIL_EN
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        ff_obs_d   = ff_obs_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = APPLY;
                    idx_d    = 2'd0;
                    stim_a_d = 1'b0;
                    stim_b_d = 1'b0;
                    timer_d  = RELOAD;
                    err_d    = 3'd0;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
`ifdef HA_CHK_FIRST_FAIL_EN
                    ff_valid_d = 1'b0;
                    ff_idx_d   = 2'd0;
                    ff_obs_d   = 2'd0;
`endif
                end
            end
            APPLY: begin
                if (timer_q == 8'd0) begin
                    state_d = CHECK;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            CHECK: begin
                // the guard keeps the counter from wrapping even though four vectors cannot reach 7
                if (mismatch && (err_q != 3'd7)) begin
                    err_d = err_q + 3'd1;
                end
`ifdef HA_CHK_FIRST_FAIL_EN
                if (mismatch && !ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_idx_d   = idx_q;
                    ff_obs_d   = {bus.dut_carry, bus.dut_sum};
                end
`endif
                if (idx_q != 2'd3) begin
                    state_d  = APPLY;
                    idx_d    = idx_inc;
                    stim_a_d = idx_inc[1];
                    stim_b_d = idx_inc[0];
                    timer_d  = RELOAD;
                end else begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    stim_a_d = 1'b0;
                    stim_b_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers; reset aborts any sweep and discards its partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= 8'd0;
            idx_q    <= 2'd0;
            err_q    <= 3'd0;
            stim_a_q <= 1'b0;
            stim_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            stim_a_q <= stim_a_d;
            stim_b_q <= stim_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef HA_CHK_FIRST_FAIL_EN
    // first-mismatch capture registers, held through DONE until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_valid_q <= 1'b0;
            ff_idx_q   <= 2'd0;
            ff_obs_q   <= 2'd0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_obs_q   <= ff_obs_d;
        end
    end

    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_idx   = ff_idx_q;
    assign bus.first_fail_obs   = ff_obs_q;
`endif

    assign bus.stim_a    = stim_a_q;
    assign bus.stim_b    = stim_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_count = err_q;
    assign bus.vec_idx   = idx_q;
    assign bus.pass      = done_q && (err_q == 3'd0);

endmodule

// File: doc/ha_response_checker.md
HA_RESPONSE_CHECKER -- requirements
Module: ha_response_checker

Interface
REQ-001 Parameter PERIOD, default 20: clock cycles each vector is held before its response is sampled; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to run the full vector sweep.
REQ-005 dut_sum  input  1  sum returned by the half-adder under test.
REQ-006 dut_carry  input  1  carry returned by the half-adder under test.
REQ-007 stim_a  output  1  operand a driven to the half-adder under test.
REQ-008 stim_b  output  1  operand b driven to the half-adder under test.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until the next accepted start.
REQ-011 pass  output  1  valid when done=1; high iff err_count==0.
REQ-012 err_count  output  3  number of mismatching vectors in the last sweep.
REQ-013 vec_idx  output  2  index of the vector currently applied.

Function
REQ-014 Vector order, fixed: idx0 a=0 b=0; idx1 a=0 b=1; idx2 a=1 b=0; idx3 a=1 b=1.
REQ-015 Expected response: sum = a XOR b; carry = a AND b.
REQ-016 FSM states: IDLE, APPLY, CHECK, DONE.
REQ-017 IDLE or DONE with start=1 -> APPLY next cycle; vec_idx=0, stim from idx0, timer=PERIOD-1, err_count cleared, done cleared, busy set.
REQ-018 APPLY: stim_a/stim_b held at current vector; timer decrements each cycle; at timer==0 -> CHECK.
REQ-019 CHECK, one cycle: compare dut_sum/dut_carry to expected; on any mismatch err_count increments.
REQ-020 CHECK with vec_idx<3 -> APPLY; vec_idx+1, stim updated to new vector on the same edge, timer reloaded to PERIOD-1.
REQ-021 CHECK with vec_idx==3 -> DONE; busy low, done high, stim_a/stim_b return to 0.
REQ-022 Sweep latency: start-accept to done-high = 4*(PERIOD+1) cycles.
REQ-023 start while busy is ignored; sweep continues unchanged.
REQ-024 start in DONE restarts a sweep per REQ-017; done drops on the accepting edge.
REQ-025 err_count never exceeds 4; increment saturates at 7 by design guard.
REQ-026 pass = done AND (err_count==0); pass is 0 whenever done=0.

Reset
REQ-027 rst_n low forces, asynchronously: state IDLE; stim_a=0, stim_b=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, timer=0.
REQ-028 Reset asserted mid-sweep aborts it; no partial result is retained; after release the block waits in IDLE for start.

Configuration
REQ-029 Macro HA_CHK_FIRST_FAIL_EN defined: extra outputs first_fail_valid (1), first_fail_idx (2), first_fail_obs (2, {carry,sum}) capture the first mismatching vector of a sweep, cleared on start and reset, held through DONE.
REQ-030 Macro undefined: those ports are absent and no capture logic is built; all other behaviour identical.

Verification
REQ-031 Correct DUT model, PERIOD=20, pulse start -> done at 84 cycles after accept, pass=1, err_count=0.
REQ-032 DUT with carry stuck at 0 -> done, err_count=1, pass=0; with macro, first_fail_idx=3, first_fail_obs=2'b00.
REQ-033 DUT computing sum=a OR b -> err_count=1 (idx3 fails); all four vectors observed on stim_a/stim_b in order, each held 20 cycles.
REQ-034 start pulsed at cycle 30 of a sweep -> ignored; done still at 84 cycles after first accept.
REQ-035 rst_n low at vec_idx=2 -> all outputs 0 immediately; after release, busy stays 0 until start.
REQ-036 PERIOD=2, back-to-back start in DONE -> second sweep clears done/err_count and completes 12 cycles later.
